// File: rtl/ad7124_pkg.sv
// Shared types and encodings for the AD7124 sequencer and its configuration table.
package ad7124_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_XFER,
    ST_POR_WAIT,
    ST_CFG_LOAD,
    ST_CFG_XFER,
    ST_CFG_GAP,
    ST_WAIT_RDY,
    ST_RD_XFER,
    ST_RD_GAP
  } state_t;

  localparam logic [1:0] SPI_LEN_24 = 2'b00;
  localparam logic [1:0] SPI_LEN_32 = 2'b01;
  localparam logic [1:0] SPI_LEN_40 = 2'b10;
  localparam logic [1:0] SPI_LEN_64 = 2'b11;

  localparam logic [7:0] AD7124_CMD_RD_DATA = 8'h42;

  // STATUS byte sits in the low 8 bits of the 32-bit receive window
  localparam int STATUS_ERR_BIT = 6;
  localparam int STATUS_CH_MSB  = 3;
  localparam int STATUS_CH_LSB  = 0;

  function automatic logic [31:0] tc_load(input int unsigned cycles);
    return (cycles == 0) ? 32'd0 : cycles - 32'd1;
  endfunction

endpackage

// File: rtl/ad7124_cfg_table.sv
// Host-programmable register-write table: {wide, cmd+value} per entry, no reset,
// synchronous write, combinational read (a same-cycle write is seen one cycle later).
module ad7124_cfg_table
  import ad7124_pkg::*;
#(
  parameter int NUM_CFG = 8
) (
  input  logic        PL_clk,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [32:0] wdata,
  input  logic [2:0]  raddr,
  output logic [32:0] rdata
);

  logic [32:0] mem [0:NUM_CFG-1];

  always_ff @(posedge PL_clk) begin
    if (we && (int'(waddr) < NUM_CFG)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < NUM_CFG) ? mem[raddr] : '0;

endmodule

// File: rtl/ad7124_seq_ctrl.sv
// AD7124 sequencer: serial interface reset, power-on wait, table-driven register writes,
// then a continuous DATA+STATUS read loop, all through one shared SPI shift engine.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for start
// RST_XFER  | 64 ones on DIN to reset the serial interface
// POR_WAIT  | power-on settle after the interface reset
// CFG_LOAD  | fetch table entry idx and request its transfer
// CFG_XFER  | config write in flight
// CFG_GAP   | CS-high gap after a config write
// WAIT_RDY  | waiting for DOUT/RDY low, or timeout
// RD_XFER   | DATA+STATUS read in flight
// RD_GAP    | CS-high gap after a read
module ad7124_seq_ctrl
  import ad7124_pkg::*;
#(
  parameter int NUM_CFG     = 8,
  parameter int POR_CYCLES  = 50000,
  parameter int GAP_CYCLES  = 800,
  parameter int RDY_TIMEOUT = 16777216
) (
  input  logic        PL_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        cfg_wide,
  input  logic [3:0]  cfg_num,
  output logic        spi_start,
  output logic [1:0]  spi_len,
  output logic [63:0] spi_tx,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [31:0] spi_rx,
  input  logic        rdy_n,
  output logic [23:0] adc_data,
  output logic [3:0]  adc_chan,
  output logic        adc_err,
  output logic        adc_valid,
  output logic        cfg_done,
  output logic        timeout
);

  state_t      state;
  logic [31:0] cnt;
  logic [3:0]  idx;
  logic [3:0]  idx_next;
  logic [3:0]  num_eff;
  logic        req_sent;
  logic        abort;
  logic        rdy_s1, rdy_s2, rdy_s3;
  logic        rdy_event;
  logic        can_issue;
  logic        in_xfer;
  logic [32:0] entry;
  logic        unused_status;

  ad7124_cfg_table #(.NUM_CFG(NUM_CFG)) u_cfg_table (
    .PL_clk (PL_clk),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wdata  ({cfg_wide, cfg_data}),
    .raddr  (idx[2:0]),
    .rdata  (entry)
  );

  always_ff @(posedge PL_clk or negedge rst) begin
    if (!rst) begin
      rdy_s1 <= 1'b1;
      rdy_s2 <= 1'b1;
      rdy_s3 <= 1'b1;
    end else begin
      rdy_s1 <= rdy_n;
      rdy_s2 <= rdy_s1;
      rdy_s3 <= rdy_s2;
    end
  end

  assign rdy_event     = !rdy_s2 && !rdy_s3;
  assign can_issue     = !spi_busy && !spi_start;
  assign in_xfer       = (state == ST_RST_XFER) || (state == ST_CFG_XFER) || (state == ST_RD_XFER);
  assign num_eff       = (int'(cfg_num) > NUM_CFG) ? 4'(NUM_CFG) : cfg_num;
  assign idx_next      = idx + 4'd1;
  assign unused_status = ^{spi_rx[7], spi_rx[5:4]};

  always_ff @(posedge PL_clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      spi_start <= 1'b0;
      spi_len   <= SPI_LEN_24;
      spi_tx    <= '0;
      adc_data  <= '0;
      adc_chan  <= '0;
      adc_err   <= 1'b0;
      adc_valid <= 1'b0;
      cfg_done  <= 1'b0;
      timeout   <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      req_sent  <= 1'b0;
      abort     <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      adc_valid <= 1'b0;
      if (!start) begin
        cfg_done <= 1'b0;
        timeout  <= 1'b0;
      end
      // a transfer already on the wire must finish before leaving its state
      if (!start && !in_xfer) begin
        state <= ST_IDLE;
        abort <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_RST_XFER;
            req_sent <= 1'b0;
            abort    <= 1'b0;
            idx      <= '0;
          end

          ST_RST_XFER: begin
            if (!req_sent) begin
              if (!start) begin
                state <= ST_IDLE;
              end else if (can_issue) begin
                spi_start <= 1'b1;
                spi_len   <= SPI_LEN_64;
                spi_tx    <= '1;
                req_sent  <= 1'b1;
              end
            end else if (spi_done) begin
              if (abort || !start) begin
                state <= ST_IDLE;
              end else begin
                state <= ST_POR_WAIT;
                cnt   <= tc_load(POR_CYCLES);
              end
            end else if (!start) begin
              abort <= 1'b1;
            end
          end

          ST_POR_WAIT: begin
            if (cnt == 32'd0) begin
              idx <= '0;
              if (num_eff == 4'd0) begin
                state    <= ST_WAIT_RDY;
                cfg_done <= 1'b1;
                cnt      <= tc_load(RDY_TIMEOUT);
              end else begin
                state <= ST_CFG_LOAD;
              end
            end else begin
              cnt <= cnt - 32'd1;
            end
          end

          ST_CFG_LOAD: begin
            if (can_issue) begin
              spi_start <= 1'b1;
              spi_len   <= entry[32] ? SPI_LEN_32 : SPI_LEN_24;
              spi_tx    <= {entry[31:0], 32'h0};
              state     <= ST_CFG_XFER;
            end
          end

          ST_CFG_XFER: begin
            if (spi_done) begin
              if (abort || !start) begin
                state <= ST_IDLE;
              end else begin
                state <= ST_CFG_GAP;
                cnt   <= tc_load(GAP_CYCLES);
              end
            end else if (!start) begin
              abort <= 1'b1;
            end
          end

          ST_CFG_GAP: begin
            if (cnt == 32'd0) begin
              if (idx_next >= num_eff) begin
                state    <= ST_WAIT_RDY;
                cfg_done <= 1'b1;
                cnt      <= tc_load(RDY_TIMEOUT);
              end else begin
                idx   <= idx_next;
                state <= ST_CFG_LOAD;
              end
            end else begin
              cnt <= cnt - 32'd1;
            end
          end

          ST_WAIT_RDY: begin
            if (rdy_event) begin
              state    <= ST_RD_XFER;
              req_sent <= 1'b0;
            end else if (cnt == 32'd0) begin
              timeout  <= 1'b1;
              state    <= ST_RD_XFER;
              req_sent <= 1'b0;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end

          ST_RD_XFER: begin
            if (!req_sent) begin
              if (!start) begin
                state <= ST_IDLE;
              end else if (can_issue) begin
                spi_start <= 1'b1;
                spi_len   <= SPI_LEN_40;
                spi_tx    <= {AD7124_CMD_RD_DATA, 56'h0};
                req_sent  <= 1'b1;
              end
            end else if (spi_done) begin
              if (abort || !start) begin
                state <= ST_IDLE;
              end else begin
                adc_data  <= spi_rx[31:8];
                adc_chan  <= spi_rx[STATUS_CH_MSB:STATUS_CH_LSB];
                adc_err   <= spi_rx[STATUS_ERR_BIT];
                adc_valid <= 1'b1;
                state     <= ST_RD_GAP;
                cnt       <= tc_load(GAP_CYCLES);
              end
            end else if (!start) begin
              abort <= 1'b1;
            end
          end

          ST_RD_GAP: begin
            if (cnt == 32'd0) begin
              state <= ST_WAIT_RDY;
              cnt   <= tc_load(RDY_TIMEOUT);
            end else begin
              cnt <= cnt - 32'd1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad7124_seq_ctrl.sv
// Bench for ad7124_seq_ctrl: behavioural SPI engine, shadow config table and
// sample arithmetic as the reference; directed phases with randomized payloads.
module tb_ad7124_seq_ctrl;
  localparam int NUM_CFG = 8;
  localparam int POR     = 100;
  localparam int GAP     = 20;
  localparam int RTO     = 300;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        PL_clk = 1'b0;
  logic        rst, start, cfg_we, cfg_wide, spi_busy, spi_done, rdy_n;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data, spi_rx;
  logic [3:0]  cfg_num;
  logic        spi_start, adc_err, adc_valid, cfg_done, timeout;
  logic [1:0]  spi_len;
  logic [63:0] spi_tx;
  logic [23:0] adc_data;
  logic [3:0]  adc_chan;

  ad7124_seq_ctrl #(.NUM_CFG(NUM_CFG), .POR_CYCLES(POR), .GAP_CYCLES(GAP), .RDY_TIMEOUT(RTO)) dut (
    .PL_clk(PL_clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_wide(cfg_wide), .cfg_num(cfg_num), .spi_start(spi_start),
    .spi_len(spi_len), .spi_tx(spi_tx), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_rx(spi_rx), .rdy_n(rdy_n), .adc_data(adc_data), .adc_chan(adc_chan),
    .adc_err(adc_err), .adc_valid(adc_valid), .cfg_done(cfg_done), .timeout(timeout)
  );

  always #10 PL_clk = ~PL_clk;

  typedef struct {
    logic [1:0]  len;
    logic [63:0] tx;
    int          t;
  } xfer_t;

  xfer_t       xfer_q[$];
  int          done_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  int          valid_t = 0;
  int          proto_err = 0;
  logic [31:0] rx_val = 32'h0;
  logic [32:0] shadow [NUM_CFG];
  logic [23:0] exp_data = 24'h0;

  always @(posedge PL_clk) cyc <= cyc + 1;

  function automatic int xfer_cycles(input logic [1:0] len);
    case (len)
      2'b00:   return 6;
      2'b01:   return 8;
      2'b10:   return 10;
      default: return 16;
    endcase
  endfunction

  // SPI engine model plus output monitor
  initial begin : spi_model
    int  remaining;
    bit  prev_start;
    remaining  = 0;
    prev_start = 1'b0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx = 32'h0;
    forever begin
      @(negedge PL_clk);
      if (adc_valid) begin valid_cnt++; valid_t = cyc; end
      if (spi_start && prev_start) proto_err++;
      prev_start = spi_start;
      spi_done = 1'b0;
      if (remaining > 0) begin
        if (spi_start) proto_err++;
        remaining--;
        if (remaining == 0) begin
          spi_rx = rx_val; spi_done = 1'b1; spi_busy = 1'b0;
          done_q.push_back(cyc);
        end
      end else if (spi_start) begin
        xfer_q.push_back('{len: spi_len, tx: spi_tx, t: cyc});
        spi_busy  = 1'b1;
        remaining = xfer_cycles(spi_len);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input int a, input logic [31:0] d, input logic w);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d; cfg_wide = w;
    shadow[a] = {w, d};
    @(negedge PL_clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_q(input int target, input int budget, input string tag);
    int n = 0;
    while (xfer_q.size() < target && n < budget) begin @(negedge PL_clk); n++; end
    check({tag, "_xfer_seen"}, 64'(xfer_q.size() >= target), 64'd1);
  endtask

  task automatic wait_valid(input int v0, input int budget, input string tag);
    int n = 0;
    while (valid_cnt <= v0 && n < budget) begin @(negedge PL_clk); n++; end
    check({tag, "_valid_seen"}, 64'(valid_cnt > v0), 64'd1);
  endtask

  task automatic verify_cfg(input int base, input int nraw, input string tag);
    int n, k, t_cd, w;
    n = (nraw > NUM_CFG) ? NUM_CFG : nraw;
    wait_q(base + 1 + n, POR + (n + 1) * (GAP + 40) + 100, tag);
    check({tag, "_cfg_done_low"}, 64'(cfg_done), 64'd0);
    if (xfer_q.size() >= base + 1 + n) begin
      check({tag, "_rst_len"}, 64'(xfer_q[base].len), 64'd3);
      check({tag, "_rst_tx"}, xfer_q[base].tx, ALL_ONES);
      for (int i = 0; i < n; i++) begin
        k = base + 1 + i;
        check($sformatf("%s_len%0d", tag, i), 64'(xfer_q[k].len), shadow[i][32] ? 64'd1 : 64'd0);
        check($sformatf("%s_tx%0d", tag, i), xfer_q[k].tx, {shadow[i][31:0], 32'h0});
        check($sformatf("%s_space%0d", tag, i),
              64'(xfer_q[k].t - done_q[k-1] >= ((i == 0) ? POR : GAP)), 64'd1);
      end
    end
    w = 0;
    while (!cfg_done && w < POR + 200) begin @(negedge PL_clk); w++; end
    t_cd = cyc;
    check({tag, "_cfg_done"}, 64'(cfg_done), 64'd1);
    check({tag, "_xfer_count"}, 64'(xfer_q.size()), 64'(base + 1 + n));
    if (done_q.size() > base + n)
      check({tag, "_done_delay"}, 64'(t_cd - done_q[base + n] >= ((n == 0) ? POR : GAP)), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] rx, input string tag);
    int n0, v0, t_low;
    n0 = xfer_q.size(); v0 = valid_cnt;
    rx_val = rx;
    repeat ($urandom_range(GAP + 5, GAP + 60)) @(negedge PL_clk);
    rdy_n = 1'b0; t_low = cyc;
    wait_q(n0 + 1, 40, tag);
    rdy_n = 1'b1;
    if (xfer_q.size() > n0) begin
      check({tag, "_len"}, 64'(xfer_q[n0].len), 64'd2);
      check({tag, "_tx"}, xfer_q[n0].tx, {8'h42, 56'h0});
      check({tag, "_latency"}, 64'(xfer_q[n0].t - t_low <= 6), 64'd1);
    end
    wait_valid(v0, 60, tag);
    repeat (5) @(negedge PL_clk);
    check({tag, "_pulses"}, 64'(valid_cnt - v0), 64'd1);
    if (done_q.size() > 0) check({tag, "_valid_time"}, 64'(valid_t), 64'(done_q[$] + 1));
    exp_data = 24'(rx / 256);
    check({tag, "_data"}, 64'(adc_data), 64'(exp_data));
    check({tag, "_chan"}, 64'(adc_chan), 64'(rx % 16));
    check({tag, "_err"}, 64'(adc_err), 64'((rx / 64) % 2));
    check({tag, "_no_timeout"}, 64'(timeout), 64'd0);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge PL_clk);
    $display("FAIL watchdog: run exceeded cycle limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          n0, v0, d0, d_prev, base, num;
    logic [31:0] rx;

    rst = 1'b0; start = 1'b1; rdy_n = 1'b1;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 32'h0; cfg_wide = 1'b0; cfg_num = 4'd2;
    @(negedge PL_clk);
    write_entry(0, 32'h0100_8300, 1'b0);
    write_entry(1, 32'h034F_0000, 1'b1);
    repeat (3) @(negedge PL_clk);
    check("rst_spi_start", 64'(spi_start), 64'd0);
    check("rst_spi_tx", spi_tx, 64'd0);
    check("rst_spi_len", 64'(spi_len), 64'd0);
    check("rst_adc_valid", 64'(adc_valid), 64'd0);
    check("rst_adc_data", 64'(adc_data), 64'd0);
    check("rst_cfg_done", 64'(cfg_done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);

    // boot with start held through reset
    rst = 1'b1;
    verify_cfg(0, 2, "boot");
    if (xfer_q.size() >= 3) begin
      check("boot_cfg0_word", 64'(xfer_q[1].tx[63:40]), 64'h010083);
      check("boot_cfg1_word", 64'(xfer_q[2].tx[63:32]), 64'h034F0000);
    end

    do_read(32'h1234_5681, "rd_fixed");
    check("rd_fixed_literal", 64'(adc_data), 64'h123456);
    for (int i = 0; i < 4; i++) do_read($urandom, $sformatf("rd_rand%0d", i));

    // DOUT/RDY never falls: forced read after the timeout window
    n0 = xfer_q.size(); v0 = valid_cnt;
    d_prev = (done_q.size() > 0) ? done_q[$] : 0;
    rx = $urandom; rx_val = rx;
    wait_q(n0 + 1, GAP + RTO + 100, "tmo");
    check("tmo_flag", 64'(timeout), 64'd1);
    if (xfer_q.size() > n0) begin
      check("tmo_len", 64'(xfer_q[n0].len), 64'd2);
      check("tmo_window", 64'(xfer_q[n0].t - d_prev >= GAP + RTO), 64'd1);
    end
    wait_valid(v0, 60, "tmo");
    exp_data = 24'(rx / 256);
    check("tmo_data", 64'(adc_data), 64'(exp_data));
    check("tmo_sticky", 64'(timeout), 64'd1);
    start = 1'b0;
    repeat (3) @(negedge PL_clk);
    check("tmo_cleared", 64'(timeout), 64'd0);
    check("tmo_cfg_done_cleared", 64'(cfg_done), 64'd0);
    repeat (20) @(negedge PL_clk);

    // empty table goes straight to the read loop
    cfg_num = 4'd0;
    base = xfer_q.size();
    start = 1'b1;
    verify_cfg(base, 0, "empty");

    // abort while the read is on the wire
    n0 = xfer_q.size(); v0 = valid_cnt; d0 = done_q.size();
    rx_val = $urandom;
    rdy_n = 1'b0;
    wait_q(n0 + 1, 40, "abort");
    rdy_n = 1'b1;
    start = 1'b0;
    while (done_q.size() <= d0 && cyc < 50000) @(negedge PL_clk);
    repeat (40) @(negedge PL_clk);
    check("abort_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("abort_data_held", 64'(adc_data), 64'(exp_data));
    check("abort_cfg_done", 64'(cfg_done), 64'd0);
    check("abort_no_more_xfer", 64'(xfer_q.size()), 64'(n0 + 1));

    // random tables, including cfg_num above the table depth
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < NUM_CFG; i++) write_entry(i, $urandom, 1'($urandom_range(0, 1)));
      num = (it == 0) ? $urandom_range(1, 8) : $urandom_range(9, 15);
      cfg_num = 4'(num);
      base = xfer_q.size();
      start = 1'b1;
      verify_cfg(base, num, $sformatf("rand_cfg%0d", it));
      do_read($urandom, $sformatf("rand_cfg%0d_rd", it));
      start = 1'b0;
      repeat (30) @(negedge PL_clk);
    end

    check("spi_protocol", 64'(proto_err), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad7124_seq_ctrl.md
Name: ad7124_seq_ctrl

Overview:
- Sequencer that owns one SPI shift engine for the AD7124 thermocouple ADC.
- On `start` it runs, in order: serial interface reset, power-on wait, a host-programmable register-write table, then a continuous conversion read loop.
- In the read loop it waits on DOUT/RDY, then reads DATA plus STATUS and delivers samples.
- Sits between the host register bank and the generic SPI master; replaces the fixed hard-coded configuration sequencing.

Parameters:
- NUM_CFG, 8, depth of the configuration table (max entries).
- POR_CYCLES, 50000, wait after interface reset (1 ms at 50 MHz).
- GAP_CYCLES, 800, idle cycles between consecutive SPI transfers, CS high.
- RDY_TIMEOUT, 16777216, cycles allowed in WAIT_RDY before timeout.

Ports:
- PL_clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; high = run sequence, low = abort to IDLE.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  3  table entry index.
- cfg_data  in  32  entry payload, left-aligned: {cmd byte, reg value}.
- cfg_wide  in  1  entry length: 0 = 24-bit transfer, 1 = 32-bit transfer.
- cfg_num  in  4  number of valid entries, 0..NUM_CFG.
- spi_start  out  1  one-cycle transfer request.
- spi_len  out  2  transfer length: 00 = 24, 01 = 32, 10 = 40, 11 = 64 bits.
- spi_tx  out  64  MSB-first transmit word, left-aligned.
- spi_busy  in  1  engine busy.
- spi_done  in  1  one-cycle pulse, transfer finished.
- spi_rx  in  32  last 32 received bits.
- rdy_n  in  1  raw DOUT/RDY pin, asynchronous.
- adc_data  out  24  conversion result.
- adc_chan  out  4  STATUS[3:0].
- adc_err  out  1  STATUS[6] of the last sample.
- adc_valid  out  1  one-cycle sample strobe.
- cfg_done  out  1  high while in the read loop.
- timeout  out  1  sticky; cleared when start goes low.

Behaviour:
- Reset: all outputs 0, spi_tx = 0, FSM in IDLE, table contents unchanged (table has no reset).
- rdy_n passes through a 2-FF synchronizer. A ready event is 2 consecutive synced-low samples.
- Table writes are accepted in any state; entries being consumed are read at CFG_LOAD time.
- FSM states and transitions:
  - IDLE: start=1 -> RST_XFER.
  - RST_XFER: spi_start, len=11, tx = all ones; on spi_done -> POR_WAIT.
  - POR_WAIT: count POR_CYCLES; then -> CFG_LOAD, or -> WAIT_RDY if cfg_num = 0.
  - CFG_LOAD: spi_tx = {cfg_data, 32'h0}; len = cfg_wide ? 01 : 00; spi_start -> CFG_XFER.
  - CFG_XFER: on spi_done -> CFG_GAP.
  - CFG_GAP: count GAP_CYCLES; then idx+1; if idx+1 = cfg_num -> WAIT_RDY (cfg_done := 1), else -> CFG_LOAD.
  - WAIT_RDY: ready event -> RD_XFER. Counter reaching RDY_TIMEOUT -> timeout := 1 and -> RD_XFER anyway (forced read).
  - RD_XFER: tx = {8'h42, 56'h0}, len = 10; on spi_done -> RD_GAP, capture adc_data = spi_rx[31:8], adc_chan = spi_rx[3:0], adc_err = spi_rx[6]; adc_valid pulses the cycle after spi_done.
  - RD_GAP: GAP_CYCLES -> WAIT_RDY.
- spi_start is asserted only when spi_busy = 0. It is held off while busy, and is never asserted 2 cycles in a row.
- start deasserted:
  - From a non-transfer state: -> IDLE next cycle.
  - From an XFER state: wait for spi_done, then -> IDLE. Results of an aborted read are discarded (no adc_valid).
  - On entry to IDLE: cfg_done and timeout cleared; adc_* hold their last value.
- start reasserted returns to RST_XFER; the full sequence always reruns.
- Latency: ready event -> spi_start within 3 cycles.
- Counters saturate; idx wraps never, because cfg_num > NUM_CFG is clamped to NUM_CFG.
- Simultaneous cfg_we and a CFG_LOAD read of the same index: CFG_LOAD uses the old entry (read-before-write).
- rst asserted mid-transfer: immediate return to IDLE; the SPI master is reset by the same rst.

Decomposition:
- Package ad7124_pkg holds:
  - state enum;
  - SPI_LEN_24/32/40/64 encodings;
  - AD7124_CMD_RD_DATA = 8'h42;
  - STATUS bit indices.
- One sub-module: ad7124_cfg_table, the NUM_CFG x 33-bit register file with synchronous write and combinational read.

Test Plan:
- Reset with start=1 held: after rst releases, first spi_start has len=11 and tx=64'hFFFF_FFFF_FFFF_FFFF; the next spi_start occurs ≥ POR_CYCLES later.
- Table write {0x01_0083, w=0}, {0x03_4F0000_, w=1}, cfg_num=2 -> two transfers: len 00 tx[63:40]=0x010083, then len 01 tx[63:32]=0x034F0000; gaps ≥ 800 cycles; cfg_done rises after the second gap.
- Read loop: drive rdy_n low, SPI model returns spi_rx=0x12345681 -> adc_data=0x123456, adc_chan=1, adc_err=0, single adc_valid pulse.
- Hold rdy_n high in WAIT_RDY for RDY_TIMEOUT cycles -> timeout=1, forced read issued; timeout clears when start drops.
- Drop start mid RD_XFER -> no adc_valid, IDLE after spi_done; raise start -> sequence restarts with the 64-bit reset transfer.
- cfg_num=0 -> after POR_WAIT, directly to WAIT_RDY with cfg_done=1 and no config transfers.
